// File: rtl/serial_shifter_pkg.sv
// Shared types and constants for the multi-cycle serial shifter.
package serial_shifter_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      SHIFT_SLL  = 2'b00,
      SHIFT_ROTR = 2'b01,
      SHIFT_SRL  = 2'b10,
      SHIFT_SRA  = 2'b11
   } shiftop_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/serial_shifter_shift_step.sv
// One-position shift step for the serial shifter; rotate path exists only when
// ROTATE_EN is defined, otherwise the rotate opcode produces zero.
module shift_step
   import serial_shifter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  shiftop_e              op_i,
   output logic [DATA_WIDTH-1:0] data_c
);

   always_comb begin
      data_c = '0;
      case (op_i)
         SHIFT_SLL:  data_c = {data_i[DATA_WIDTH-2:0], 1'b0};
         SHIFT_SRL:  data_c = {1'b0, data_i[DATA_WIDTH-1:1]};
         SHIFT_SRA:  data_c = {data_i[DATA_WIDTH-1], data_i[DATA_WIDTH-1:1]};
`ifdef ROTATE_EN
         SHIFT_ROTR: data_c = {data_i[0], data_i[DATA_WIDTH-1:1]};
`else
         SHIFT_ROTR: data_c = '0;
`endif
         default:    data_c = '0;
      endcase
   end

endmodule

// File: rtl/serial_shifter.sv
// Sequential shift unit: accept operand/amount/opcode, shift one bit per clock,
// return the result over valid/ready. Define ROTATE_EN to enable opcode 01 (ROTR).
module serial_shifter
   import serial_shifter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic [1:0]            Shiftop,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] Result
);

   localparam int unsigned CW = $clog2(DATA_WIDTH);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]         count_q, count_d;
   shiftop_e              op_q, op_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] step_c;

   shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .data_i (data_q),
      .op_i   (op_q),
      .data_c (step_c)
   );

   // Next-state, datapath and registered-handshake decode.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      count_d = count_q;
      op_d    = op_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = A;
               count_d = CW'(B);
               op_d    = shiftop_e'(Shiftop);
`ifndef ROTATE_EN
               if (shiftop_e'(Shiftop) == SHIFT_ROTR) data_d = '0;
`endif
               state_d = (CW'(B) != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            data_d  = step_c;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         data_q      <= '0;
         count_q     <= '0;
         op_q        <= SHIFT_SLL;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         count_q     <= count_d;
         op_q        <= op_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Result    = data_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Scoreboard bench for serial_shifter: directed cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_serial_shifter;

   localparam int unsigned DW = 32;

   typedef struct {
      logic [DW-1:0] res;
      int            n;
      longint        acc;
   } exp_t;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] A = '0;
   logic [DW-1:0] B = '0;
   logic [1:0]    Shiftop = 2'b00;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] Result;

   exp_t          exp_q[$];
   longint        cyc = 0;
   longint        acc_cyc_last = 0;
   longint        last_hs_cyc = 0;
   int            checks = 0;
   int            errors = 0;
   int            rdy_mode = 0;
   bit            seen = 0;
   logic [DW-1:0] held;

   serial_shifter dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Shiftop   (Shiftop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Result    (Result)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // out_ready policy: 0 = always ready, 1 = random, 2 = driven by the test
   always @(posedge clk) begin
      #2;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
   end

   function automatic logic [DW-1:0] ref_shift(logic [DW-1:0] a, logic [DW-1:0] b, logic [1:0] op);
      int n;
      n = int'(b % DW);
      case (op)
         2'b00: return a << n;
         2'b10: return a >> n;
         2'b11: return DW'($signed(a) >>> n);
         default: begin
`ifdef ROTATE_EN
            if (n == 0) return a;
            return (a >> n) | (a << (DW - n));
`else
            return '0;
`endif
         end
      endcase
   endfunction

   task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic send(logic [DW-1:0] a, logic [DW-1:0] b, logic [1:0] op);
      int t;
      exp_t e;
      @(negedge clk);
      A = a; B = b; Shiftop = op; in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready stuck low, expected 1");
         in_valid = 1'b0;
         return;
      end
      e.res = ref_shift(a, b, op);
      e.n   = int'(b % DW);
      e.acc = cyc + 1;
      exp_q.push_back(e);
      acc_cyc_last = cyc + 1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = $urandom; B = $urandom; Shiftop = 2'($urandom);
   endtask

   // Monitor: pops on the first cycle of each result, then checks it holds.
   always @(negedge clk) begin
      if (!resetn) begin
         seen = 0;
      end else if (out_valid) begin
         if (!seen) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out_valid: got result %h with nothing pending", Result);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("result", Result, e.res);
               check("latency", DW'(cyc - e.acc), DW'(e.n));
            end
            seen = 1;
            held = Result;
         end else begin
            check("hold_result", Result, held);
            check("hold_in_ready", DW'(in_ready), '0);
         end
         if (out_ready) begin
            seen = 0;
            last_hs_cyc = cyc + 1;
         end
      end
   end

   initial begin
      int t;
      repeat (2) @(negedge clk);
      check("rst_in_ready", DW'(in_ready), 1);
      check("rst_out_valid", DW'(out_valid), 0);
      check("rst_result", Result, '0);
      resetn = 1'b1;

      send(32'h0000_0001, 32'd4, 2'b00);
      send(32'h8000_0000, 32'd31, 2'b11);
      send(32'h8000_0000, 32'd31, 2'b10);
      send(32'hDEAD_BEEF, 32'd0, 2'b00);
      send(32'hDEAD_BEEF, 32'd32, 2'b00);
      send(32'h0000_00F1, 32'd4, 2'b01);

      // Backpressure: result held 5+ cycles, queued request waits for handshake
      t = 0;
      while ((exp_q.size() != 0 || seen) && t < 200) begin @(negedge clk); t++; end
      rdy_mode = 2;
      @(posedge clk); #2 out_ready = 1'b0;
      send(32'h0000_00F0, 32'd4, 2'b10);
      t = 0;
      while (!out_valid && t < 100) begin @(negedge clk); t++; end
      fork
         send(32'h1234_5678, 32'd8, 2'b00);
         begin
            repeat (5) @(negedge clk);
            @(posedge clk); #2 out_ready = 1'b1;
         end
      join
      check("accept_after_hs", DW'(acc_cyc_last - last_hs_cyc), 1);
      rdy_mode = 0;

      // Reset during SHIFT abandons the operation
      t = 0;
      while ((exp_q.size() != 0 || seen) && t < 200) begin @(negedge clk); t++; end
      send(32'hCAFE_F00D, 32'd20, 2'b10);
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midrst_out_valid", DW'(out_valid), 0);
      check("midrst_result", Result, '0);
      check("midrst_in_ready", DW'(in_ready), 1);
      resetn = 1'b1;
      repeat (30) @(negedge clk);
      send(32'hCAFE_F00D, 32'd20, 2'b10);

      // Randomized traffic with random backpressure
      rdy_mode = 1;
      for (int i = 0; i < 60; i++) begin
         send($urandom, DW'($urandom_range(0, 40)), 2'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      rdy_mode = 0;

      t = 0;
      while ((exp_q.size() != 0 || seen) && t < 3000) begin @(negedge clk); t++; end
      if (exp_q.size() != 0 || seen) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
